mercury_dac_if: RTL and testbench

- Downstream consumer of the audio block's surfaced 16-bit PSG and PCM channels; drives the MercuryII board's dual-channel 12-bit SPI DAC (MCP4922-style) in place of the I2S path.
- On each `next_sample` strobe:
  - mixes PSG+PCM per channel with saturation;
  - converts to 12-bit offset binary;
  - shifts left then right frames out over SPI;
  - pulses LDAC so both channels update together.
- Single clock domain (`clk`).

---
 rtl/mercury_dac_if.sv | 229 ++++++++++++++++++++++
 tb/tb_mercury_dac_if.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mercury_dac_if.sv
// mercury_dac_if: mixes PSG+PCM audio per channel, converts to 12-bit offset
// binary and ships left/right frames to a dual-channel SPI DAC, then pulses
// LDAC so both channels update together.
module mercury_dac_if #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [3:0]  CMD_LEFT  = 4'b0011,
    parameter logic [3:0]  CMD_RIGHT = 4'b1011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_sample,
    input  logic [15:0] psg_left,
    input  logic [15:0] psg_right,
    input  logic [15:0] pcm_left,
    input  logic [15:0] pcm_right,
    input  logic        overrun_clr,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdi,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned SW = 16;   // sample width
    localparam int unsigned DW = 12;   // DAC data width
    localparam int unsigned FW = 16;   // SPI frame width
    localparam int unsigned CW = 4;    // phase counter width (covers 2*7-1)
    localparam int unsigned BW = 4;    // bit index width

    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L_SETUP,
        ST_L_SHIFT,
        ST_L_GAP,
        ST_R_SETUP,
        ST_R_SHIFT,
        ST_R_GAP,
        ST_LDAC
    } state_t;

    // Saturating 17-bit add, then top 12 bits with the sign flipped to offset binary
    function automatic logic [DW-1:0] f_mix(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0]   sum;
        logic [SW-1:0] sat;
        sum = {a[SW-1], a} + {b[SW-1], b};
        if (sum[SW] != sum[SW-1]) begin
            sat = sum[SW] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat = sum[SW-1:0];
        end
        return {~sat[SW-1], sat[SW-2:SW-DW]};
    endfunction

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [BW-1:0]  r_bit;
    logic [FW-1:0]  r_sh;
    logic [FW-1:0]  r_frame_r;
    logic           r_cs_n;
    logic           r_sclk;
    logic           r_sdi;
    logic           r_ldac_n;
    logic           r_busy;
    logic           r_overrun;
    logic           r_slot_vld;
    logic [DW-1:0]  r_slot_l;
    logic [DW-1:0]  r_slot_r;

    logic [DW-1:0]  w_mix_l;
    logic [DW-1:0]  w_mix_r;
    logic [DW-1:0]  w_cap_l;
    logic [DW-1:0]  w_cap_r;
    logic           w_in_xfer;
    logic           w_start;
    logic           w_half_end;
    logic           w_gap_end;

    assign w_mix_l    = f_mix(psg_left,  pcm_left);
    assign w_mix_r    = f_mix(psg_right, pcm_right);
    // A waiting sample is older than a strobe arriving in the same cycle, so it goes first
    assign w_cap_l    = r_slot_vld ? r_slot_l : w_mix_l;
    assign w_cap_r    = r_slot_vld ? r_slot_r : w_mix_r;
    assign w_in_xfer  = (r_state != ST_IDLE);
    assign w_start    = !w_in_xfer && (next_sample || r_slot_vld);
    assign w_half_end = (r_cnt == HALF_LAST);
    assign w_gap_end  = (r_cnt == GAP_LAST);

    assign dac_cs_n   = r_cs_n;
    assign dac_sclk   = r_sclk;
    assign dac_sdi    = r_sdi;
    assign dac_ldac_n = r_ldac_n;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

    // Pending slot and sticky overrun flag (set wins over clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_vld <= 1'b0;
            r_slot_l   <= '0;
            r_slot_r   <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                if (next_sample) begin
                    r_slot_vld <= 1'b1;
                    r_slot_l   <= w_mix_l;
                    r_slot_r   <= w_mix_r;
                end
            end else if (r_slot_vld) begin
                r_slot_vld <= next_sample;
                if (next_sample) begin
                    r_slot_l <= w_mix_l;
                    r_slot_r <= w_mix_r;
                end
            end

            if (w_in_xfer && next_sample && r_slot_vld) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Transfer sequencer: setup, 16 SCLK bits, gap per channel, then LDAC pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
            r_frame_r <= '0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_sdi     <= 1'b0;
            r_ldac_n  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sh      <= {CMD_LEFT, w_cap_l};
                        r_frame_r <= {CMD_RIGHT, w_cap_r};
                        r_sdi     <= CMD_LEFT[3];
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_L_SETUP;
                    end
                end

                ST_L_SETUP, ST_R_SETUP: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= (r_state == ST_L_SETUP) ? ST_L_SHIFT : ST_R_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_L_SHIFT, ST_R_SHIFT: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (r_sclk) begin
                            // Falling edge: present the next bit; zeros trail the last one
                            r_sclk <= 1'b0;
                            r_sdi  <= r_sh[FW-2];
                            r_sh   <= {r_sh[FW-2:0], 1'b0};
                        end else if (r_bit == BIT_LAST) begin
                            r_cs_n  <= 1'b1;
                            r_sdi   <= 1'b0;
                            r_state <= (r_state == ST_L_SHIFT) ? ST_L_GAP : ST_R_GAP;
                        end else begin
                            r_bit  <= r_bit + BW'(1);
                            r_sclk <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_L_GAP: begin
                    if (w_gap_end) begin
                        r_cnt   <= '0;
                        r_sh    <= r_frame_r;
                        r_sdi   <= r_frame_r[FW-1];
                        r_cs_n  <= 1'b0;
                        r_state <= ST_R_SETUP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_R_GAP: begin
                    if (w_gap_end) begin
                        r_cnt    <= '0;
                        r_ldac_n <= 1'b0;
                        r_state  <= ST_LDAC;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_LDAC: begin
                    if (w_gap_end) begin
                        r_cnt    <= '0;
                        r_ldac_n <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mercury_dac_if.sv
// tb_mercury_dac_if: two DUT instances (CLK_DIV=2 and CLK_DIV=1) checked every
// cycle against a timeline model, plus hand-computed frame/timing expectations.
module tb_mercury_dac_if;

    localparam int unsigned NA = 2;
    localparam int unsigned NB = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ns     [2];
    logic [15:0] psgl   [2];
    logic [15:0] psgr   [2];
    logic [15:0] pcml   [2];
    logic [15:0] pcmr   [2];
    logic        oclr   [2];
    logic        cs_n   [2];
    logic        sclk   [2];
    logic        sdi    [2];
    logic        ldac_n [2];
    logic        busy   [2];
    logic        ovr    [2];

    always #5 clk = ~clk;

    mercury_dac_if #(.CLK_DIV(NA)) u_dut_a (
        .clk(clk), .rst(rst), .next_sample(ns[0]),
        .psg_left(psgl[0]), .psg_right(psgr[0]), .pcm_left(pcml[0]), .pcm_right(pcmr[0]),
        .overrun_clr(oclr[0]),
        .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_sdi(sdi[0]), .dac_ldac_n(ldac_n[0]),
        .busy(busy[0]), .overrun(ovr[0])
    );

    mercury_dac_if #(.CLK_DIV(NB)) u_dut_b (
        .clk(clk), .rst(rst), .next_sample(ns[1]),
        .psg_left(psgl[1]), .psg_right(psgr[1]), .pcm_left(pcml[1]), .pcm_right(pcmr[1]),
        .overrun_clr(oclr[1]),
        .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_sdi(sdi[1]), .dac_ldac_n(ldac_n[1]),
        .busy(busy[1]), .overrun(ovr[1])
    );

    int tests = 0;
    int fails = 0;
    int nprint = 0;
    int e = 0;
    bit chk_en = 0;

    // model state
    bit          m_act [2];
    int          m_t0  [2];
    logic [15:0] m_fl  [2];
    logic [15:0] m_fr  [2];
    bit          m_sv  [2];
    logic [11:0] m_sl  [2];
    logic [11:0] m_sr  [2];
    bit          m_ovr [2];
    int          m_ns_e[2];
    bit          m_set;

    // monitor state
    logic [15:0] sh_w   [2];
    logic [15:0] fr_w   [2][8];
    int          csl    [2][8];
    int          fr_n   [2];
    int          cs_cnt [2];
    bit          p_csl  [2];
    bit          p_sclk [2];
    bit          p_busy [2];
    bit          ld_seen[2];
    int          ld_first[2];
    int          ld_last [2];
    int          bfall   [2];

    function automatic int div(input int i);
        return (i == 0) ? int'(NA) : int'(NB);
    endfunction

    // Audio mix in plain integer arithmetic: clamp, shift to unsigned, keep top 12 bits
    function automatic logic [11:0] mix(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 12'((s + 32768) / 16);
    endfunction

    // Expected pins after the current edge, from position inside the 72N-cycle timeline
    task automatic expect_now(input int i, output logic [5:0] ex, output bit dc);
        int n, k, j, b;
        logic [15:0] f;
        bit hi;
        n  = div(i);
        dc = 0;
        ex = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_ovr[i]};
        if (m_act[i]) begin
            k = e - m_t0[i];
            ex[1] = 1'b1;
            if (k >= 70 * n) begin
                ex[2] = 1'b0;
            end else if (k < 33 * n || (k >= 35 * n && k < 68 * n)) begin
                f = (k < 33 * n) ? m_fl[i] : m_fr[i];
                if (k >= 35 * n) k = k - 35 * n;
                ex[5] = 1'b0;
                if (k < n) begin
                    ex[3] = f[15];
                end else begin
                    j = k - n;
                    b = j / (2 * n);
                    hi = (j % (2 * n)) < n;
                    ex[4] = hi;
                    if (hi) ex[3] = f[15 - b];
                    else if (b < 15) ex[3] = f[14 - b];
                    else dc = 1;
                end
            end
        end
    endtask

    // Model update on every clock edge
    always @(posedge clk) begin
        e++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 0;
                m_sv[i]  = 0;
                m_ovr[i] = 0;
            end else begin
                m_set = 0;
                if (m_act[i]) begin
                    if (e == m_t0[i] + 72 * div(i)) m_act[i] = 0;
                    if (ns[i]) begin
                        if (m_sv[i]) m_set = 1;
                        m_sv[i] = 1;
                        m_sl[i] = mix(psgl[i], pcml[i]);
                        m_sr[i] = mix(psgr[i], pcmr[i]);
                    end
                end else if (m_sv[i] || ns[i]) begin
                    m_act[i] = 1;
                    m_t0[i]  = e;
                    if (m_sv[i]) begin
                        m_fl[i] = {4'h3, m_sl[i]};
                        m_fr[i] = {4'hB, m_sr[i]};
                        m_sv[i] = ns[i];
                        if (ns[i]) begin
                            m_sl[i] = mix(psgl[i], pcml[i]);
                            m_sr[i] = mix(psgr[i], pcmr[i]);
                        end
                    end else begin
                        m_fl[i] = {4'h3, mix(psgl[i], pcml[i])};
                        m_fr[i] = {4'hB, mix(psgr[i], pcmr[i])};
                    end
                end
                if (m_set) m_ovr[i] = 1;
                else if (oclr[i]) m_ovr[i] = 0;
                if (ns[i]) m_ns_e[i] = e;
            end
        end
    end

    // Monitors and per-cycle compare, away from the active edge
    always @(negedge clk) begin
        logic [5:0] ex;
        logic [5:0] act;
        bit dc;
        for (int i = 0; i < 2; i++) begin
            if (sclk[i] === 1'b1 && !p_sclk[i]) sh_w[i] = {sh_w[i][14:0], sdi[i]};
            if (cs_n[i] === 1'b0) begin
                cs_cnt[i]++;
            end else if (p_csl[i]) begin
                if (fr_n[i] < 8) begin
                    fr_w[i][fr_n[i]] = sh_w[i];
                    csl[i][fr_n[i]]  = cs_cnt[i];
                    fr_n[i]++;
                end
                cs_cnt[i] = 0;
            end
            p_csl[i]  = (cs_n[i] === 1'b0);
            p_sclk[i] = (sclk[i] === 1'b1);
            if (ldac_n[i] === 1'b0) begin
                if (!ld_seen[i]) ld_first[i] = e;
                ld_last[i] = e;
                ld_seen[i] = 1;
            end
            if (p_busy[i] && busy[i] === 1'b0) bfall[i] = e;
            p_busy[i] = (busy[i] === 1'b1);

            if (chk_en) begin
                expect_now(i, ex, dc);
                act = {cs_n[i], sclk[i], sdi[i], ldac_n[i], busy[i], ovr[i]};
                if (dc) begin
                    ex[3]  = 1'b0;
                    act[3] = 1'b0;
                end
                tests++;
                if (act !== ex) begin
                    fails++;
                    if (nprint < 30) begin
                        nprint++;
                        $display("FAIL cycle dut%0d edge %0d: pins{cs,sclk,sdi,ldac,busy,ovr} got %b expected %b",
                                 i, e, act, ex);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fw(input int i, input int j);
        if (j < fr_n[i]) return fr_w[i][j];
        return 16'hxxxx;
    endfunction

    function automatic int cw(input int i, input int j);
        if (j < fr_n[i]) return csl[i][j];
        return -1;
    endfunction

    task automatic clr_mon(input int i);
        fr_n[i]    = 0;
        ld_seen[i] = 0;
        ld_first[i] = -1;
        ld_last[i]  = -1;
        bfall[i]    = -1;
    endtask

    // Caller sits at a negedge; the strobe is sampled at the next posedge
    task automatic pulse(input int i, input logic [15:0] pl, input logic [15:0] ml,
                         input logic [15:0] pr, input logic [15:0] mr);
        psgl[i] = pl; pcml[i] = ml; psgr[i] = pr; pcmr[i] = mr;
        ns[i] = 1'b1;
        @(negedge clk);
        ns[i] = 1'b0;
    endtask

    task automatic pins_idle(input string name, input int i);
        chk(name, 32'({cs_n[i], sclk[i], sdi[i], ldac_n[i], busy[i], ovr[i]}), 32'(6'b100100));
    endtask

    int t;

    initial begin
        for (int i = 0; i < 2; i++) begin
            ns[i] = 0; psgl[i] = 0; psgr[i] = 0; pcml[i] = 0; pcmr[i] = 0; oclr[i] = 0;
            sh_w[i] = 0; cs_cnt[i] = 0; p_csl[i] = 0; p_sclk[i] = 0; p_busy[i] = 0;
            clr_mon(i);
        end
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pins_idle("reset_a", 0);
        pins_idle("reset_b", 1);

        // Basic mix and timing, CLK_DIV=2
        clr_mon(0);
        @(negedge clk);
        pulse(0, 16'h1000, 16'h0800, 16'h0000, 16'h0000);
        t = m_ns_e[0];
        repeat (150) @(negedge clk);
        chk("frame_left", 32'(fw(0, 0)), 32'h3980);
        chk("frame_right", 32'(fw(0, 1)), 32'hB800);
        chk("cs_low_left", 32'(cw(0, 0)), 32'd66);
        chk("cs_low_right", 32'(cw(0, 1)), 32'd66);
        chk("ldac_first", 32'(ld_first[0] - t), 32'd140);
        chk("ldac_last", 32'(ld_last[0] - t), 32'd143);
        chk("busy_fall", 32'(bfall[0] - t), 32'd144);

        // Positive saturation
        clr_mon(0);
        pulse(0, 16'h7000, 16'h7000, 16'h0000, 16'h0000);
        repeat (150) @(negedge clk);
        chk("sat_pos", 32'(fw(0, 0)), 32'h3FFF);

        // Negative saturation on both channels
        clr_mon(0);
        pulse(0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        repeat (150) @(negedge clk);
        chk("sat_neg_l", 32'(fw(0, 0)), 32'h3000);
        chk("sat_neg_r", 32'(fw(0, 1)), 32'hB000);

        // Inputs changed mid-shift must not disturb the frame
        clr_mon(0);
        pulse(0, 16'h1234, 16'h0100, 16'h0000, 16'h0000);
        repeat (20) @(negedge clk);
        psgl[0] = 16'h7FFF;
        pcml[0] = 16'h7FFF;
        repeat (130) @(negedge clk);
        chk("input_hold", 32'(fw(0, 0)), 32'h3933);

        // Back-to-back strobes, CLK_DIV=1
        clr_mon(1);
        pulse(1, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        repeat (19) @(negedge clk);
        pulse(1, 16'h0020, 16'h0000, 16'h0000, 16'h0000);
        repeat (140) @(negedge clk);
        chk("b2b_n_frames", 32'(fr_n[1]), 32'd4);
        chk("b2b_first", 32'(fw(1, 0)), 32'h3801);
        chk("b2b_second", 32'(fw(1, 2)), 32'h3802);
        chk("b2b_no_ovr", 32'(ovr[1]), 32'd0);

        // Slot overwrite sets overrun
        clr_mon(1);
        pulse(1, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        repeat (19) @(negedge clk);
        pulse(1, 16'h0020, 16'h0000, 16'h0000, 16'h0000);
        repeat (9) @(negedge clk);
        pulse(1, 16'h0030, 16'h0000, 16'h0000, 16'h0000);
        chk("ovr_set", 32'(ovr[1]), 32'd1);
        repeat (140) @(negedge clk);
        chk("ovr_frame", 32'(fw(1, 2)), 32'h3803);
        chk("ovr_sticky", 32'(ovr[1]), 32'd1);
        oclr[1] = 1'b1;
        @(negedge clk);
        oclr[1] = 1'b0;
        chk("ovr_clr", 32'(ovr[1]), 32'd0);

        // Reset held 3 cycles mid right-frame shift
        clr_mon(0);
        pulse(0, 16'h4000, 16'h0000, 16'h2000, 16'h0000);
        repeat (89) @(negedge clk);
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pins_idle("rst_abort_a", 0);
        pins_idle("rst_abort_b", 1);
        repeat (150) @(negedge clk);
        chk("rst_no_ldac", 32'(ld_seen[0]), 32'd0);
        chk("rst_stays_idle", 32'(busy[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
